ksa_param_controller: RTL
=========================

// Module: ksa_param_controller
// PURPOSE
//  Parametrised RC4 key-scheduling (KSA) engine. Runs j=j+S[i]+key[i mod key_len]; swap S[i],S[j]
//  for i=0..2**AW-1 against an external single-port S RAM. Sits between the S-array init stage
//  and the PRGA/decrypt stage. Key length is runtime-selectable; RAM read latency is a parameter.
// PARAMETERS
//  AW             8  S-array address and data width; array depth = 2**AW
//  MAX_KEY_BYTES  3  maximum key length in bytes
//  RD_LAT         2  cycles from address driven to q valid (>=1)
// PORTS
//  clk       in   1                          system clock, rising edge
//  reset_n   in   1                          asynchronous active-low reset
//  start     in   1                          start request, sampled only in IDLE
//  key       in   8*MAX_KEY_BYTES            key; byte 0 = key[8*MAX_KEY_BYTES-1 -: 8]
//  key_len   in   $clog2(MAX_KEY_BYTES+1)    active key bytes, valid range 1..MAX_KEY_BYTES
//  busy      out  1                          high from the cycle after start acceptance through DONE
//  done      out  1                          1-cycle pulse; schedule complete
//  err       out  1                          1-cycle pulse; start rejected (bad key_len)
//  address   out  AW                         S RAM address
//  data      out  AW                         S RAM write data
//  wren      out  1                          S RAM write enable
//  q         in   AW                         S RAM read data
// BEHAVIOUR
//  - Reset, async on reset_n low: state=IDLE. i, j, kidx, si, sj, address, data, wren, busy, done, err all 0.
//  - IDLE, start=1, key_len in 1..MAX: latch key and key_len; i=j=kidx=0; go to RD_I.
//  - IDLE, start=1, key_len=0 or >MAX: pulse err next cycle. Stay IDLE. No RAM access.
//  - start outside IDLE is ignored.
//  - RD_I: address=i, wren=0. Lasts RD_LAT+1 cycles (wait counter); si<=q on the last cycle.
//  - CALC_J: 1 cycle. j <= j + si + keybyte[kidx], mod 2**AW (carry discarded).
//  - RD_J: address=j, wren=0. Lasts RD_LAT+1 cycles; sj<=q on the last cycle.
//  - WR_J: 1 cycle. wren=1, address=j, data=si.
//  - WR_I: 1 cycle. wren=1, address=i, data=sj.
//    - Same cycle: kidx <= (kidx==key_len-1) ? 0 : kidx+1.
//    - Same cycle: i <= i+1 (wraps).
//    - If i was 2**AW-1, go to DONE; else go to RD_I.
//  - DONE: done=1 for 1 cycle, then IDLE. busy drops on entry to IDLE.
//  - i==j: both writes are still issued, with identical value; no elision, timing fixed.
//  - Modulo is a wrapping counter (kidx); no divider.
//  - Per-iteration cost: 2*(RD_LAT+1)+3 cycles; default RD_LAT=2 gives 9.
//  - Start latency: start sampled at edge 0, RD_I entered cycle 1, done asserted cycle 256*9+1 = 2305.
//  - Outside WR_J/WR_I (and FILL), wren=0.
//  - address/data are registered per state; outputs are glitch-free.
//  - Reset mid-run: immediate abort to IDLE. RAM contents are left partially swapped; the caller
//    must re-initialise S.
// CONFIGURATION
//  KSA_INIT_FILL_EN defined:
//    - start enters FILL first: S[k]=k written for k=0..2**AW-1, one per cycle (wren=1), busy=1.
//    - Then RD_I with i=j=kidx=0. Default done at cycle 256+2305 = 2561.
//  KSA_INIT_FILL_EN undefined:
//    - No FILL state. S must be pre-initialised by the upstream block.
// TESTING
//  1 Assert reset_n=0 with clk running -> busy=done=err=wren=0, address=data=0; IDLE held after release.
//  2 S=identity, key byte0=0x03, key_len=1, RD_LAT=2 -> si=0 and j=3 captured.
//    Cycle 8: wren=1, addr=3, data=0. Cycle 9: wren=1, addr=0, data=3.
//  3 key_len=0, start -> err=1 at cycle 1 only; busy, done and wren never assert.
//  4 key=0x4B6579, key_len=3, S=identity -> done at cycle 2305; all 256 S bytes match a software
//    RC4 KSA model. Rerun with key_len=2 (key 0x4B65) and compare again.
//  5 Pulse start at cycle 100 during a run -> ignored, done still at 2305.
//    reset_n low at cycle 500 -> outputs 0 asynchronously. Restart after re-init -> done 2305 cycles later.
//  6 With KSA_INIT_FILL_EN, start -> cycles 1..256 write addr k, data k; done at 2561; S matches model.

Source files
------------

// File: rtl/ksa_param_controller.sv
`default_nettype none
// ksa_param_controller: RC4 key-scheduling engine driving an external single-port S RAM (rev 1.0).
// Define KSA_INIT_FILL_EN to write S[k]=k before scheduling.
module ksa_param_controller #(
    parameter int AW            = 8,
    parameter int MAX_KEY_BYTES = 3,
    parameter int RD_LAT        = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [8*MAX_KEY_BYTES-1:0]           key,
    input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]   key_len,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [AW-1:0]                        address,
    output logic [AW-1:0]                        data,
    output logic                                 wren,
    input  logic [AW-1:0]                        q
);
    localparam int KW = $clog2(MAX_KEY_BYTES+1);
    localparam int WW = $clog2(RD_LAT+1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_I   = 3'd1,
        S_CALC_J = 3'd2,
        S_RD_J   = 3'd3,
        S_WR_J   = 3'd4,
        S_WR_I   = 3'd5,
        S_DONE   = 3'd6
`ifdef KSA_INIT_FILL_EN
        , S_FILL = 3'd7
`endif
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]            kidx_q, kidx_d, klen_q, klen_d;
    logic [WW-1:0]            wait_q, wait_d;
    logic [8*MAX_KEY_BYTES-1:0] key_q, key_d;
    logic [AW-1:0]            addr_q, addr_d, data_q, data_d;
    logic                     wren_q, wren_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]               kbyte;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;
        klen_d  = klen_q;
        wait_d  = wait_q;
        key_d   = key_q;
        err_d   = 1'b0;
        kbyte   = key_q[8*(MAX_KEY_BYTES-1-int'(kidx_q)) +: 8];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (key_len != '0 && key_len <= KW'(MAX_KEY_BYTES)) begin
                        key_d  = key;
                        klen_d = key_len;
                        i_d    = '0;
                        j_d    = '0;
                        kidx_d = '0;
                        wait_d = '0;
`ifdef KSA_INIT_FILL_EN
                        state_d = S_FILL;
`else
                        state_d = S_RD_I;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef KSA_INIT_FILL_EN
            // i doubles as the fill pointer and wraps back to 0 for scheduling.
            S_FILL: begin
                i_d = i_q + AW'(1);
                if (i_q == '1) state_d = S_RD_I;
            end
`endif
            S_RD_I: begin
                if (wait_q == WW'(RD_LAT)) begin
                    si_d    = q;
                    wait_d  = '0;
                    state_d = S_CALC_J;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_CALC_J: begin
                j_d     = j_q + si_q + AW'(kbyte);
                state_d = S_RD_J;
            end
            S_RD_J: begin
                if (wait_q == WW'(RD_LAT)) begin
                    sj_d    = q;
                    wait_d  = '0;
                    state_d = S_WR_J;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WR_J: state_d = S_WR_I;
            S_WR_I: begin
                kidx_d  = (kidx_q == klen_q - KW'(1)) ? '0 : kidx_q + KW'(1);
                i_d     = i_q + AW'(1);
                state_d = (i_q == '1) ? S_DONE : S_RD_I;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so they register cleanly with it.
        addr_d = '0;
        data_d = '0;
        wren_d = 1'b0;
        case (state_d)
            S_RD_I: addr_d = i_d;
            S_RD_J: addr_d = j_d;
            S_WR_J: begin
                addr_d = j_d;
                data_d = si_d;
                wren_d = 1'b1;
            end
            S_WR_I: begin
                addr_d = i_d;
                data_d = sj_d;
                wren_d = 1'b1;
            end
`ifdef KSA_INIT_FILL_EN
            S_FILL: begin
                addr_d = i_d;
                data_d = i_d;
                wren_d = 1'b1;
            end
`endif
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            klen_q  <= '0;
            wait_q  <= '0;
            key_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            klen_q  <= klen_d;
            wait_q  <= wait_d;
            key_q   <= key_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign address = addr_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
`default_nettype wire
